// File: rtl/alu_result_stage.sv
// alu_result_stage: 2-entry in-order skid buffer after the ALU result mux.
// Define ALU_RESULT_FLAGS_EN to store zero/negative flags with each entry.
module alu_result_stage #(
  parameter int Bits    = 2,
  parameter int CntBits = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [1:0]         in_sel,
  input  logic [Bits-1:0]    in_data,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [Bits-1:0]    out_data,
  output logic [1:0]         out_sel,
  output logic               out_zero,
  output logic               out_neg,
  output logic [CntBits-1:0] acc_count
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_push;
  logic              w_pop;
  logic              w_ld_in;
  logic              w_ld_tail;
  logic              w_shift;
  logic [Bits-1:0]   r_h_data;
  logic [Bits-1:0]   r_t_data;
  logic [1:0]        r_h_sel;
  logic [1:0]        r_t_sel;
  logic [CntBits-1:0] r_cnt;

  assign in_ready  = (r_state != S_FULL);
  assign out_valid = (r_state != S_EMPTY);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // Head takes the input when it is (or becomes) the only entry.
  assign w_ld_in   = ((r_state == S_EMPTY) && w_push) ||
                     ((r_state == S_ONE) && w_push && w_pop);
  assign w_ld_tail = (r_state == S_ONE) && w_push && !w_pop;
  assign w_shift   = (r_state == S_FULL) && w_pop;

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_next;
  end

  // Next occupancy from the two transfer strobes.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_EMPTY: if (w_push) w_next = S_ONE;
      S_ONE: begin
        if (w_push && !w_pop)      w_next = S_FULL;
        else if (!w_push && w_pop) w_next = S_EMPTY;
      end
      S_FULL:  if (w_pop) w_next = S_ONE;
      default: w_next = S_EMPTY;
    endcase
  end

  // Entry data/tag storage; reset discards anything buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_data <= '0;
      r_h_sel  <= '0;
      r_t_data <= '0;
      r_t_sel  <= '0;
    end else begin
      if (w_ld_in) begin
        r_h_data <= in_data;
        r_h_sel  <= in_sel;
      end else if (w_shift) begin
        r_h_data <= r_t_data;
        r_h_sel  <= r_t_sel;
      end
      if (w_ld_tail) begin
        r_t_data <= in_data;
        r_t_sel  <= in_sel;
      end
    end
  end

  // Count accepted results, wrapping naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (w_push) r_cnt <= r_cnt + CntBits'(1);
  end

  assign acc_count = r_cnt;
  assign out_data  = out_valid ? r_h_data : '0;
  assign out_sel   = out_valid ? r_h_sel  : '0;

`ifdef ALU_RESULT_FLAGS_EN
  logic w_zero;
  logic w_neg;
  logic r_h_zero;
  logic r_h_neg;
  logic r_t_zero;
  logic r_t_neg;

  assign w_zero = (in_data == '0);
  assign w_neg  = in_data[Bits-1];

  // Flags are captured at acceptance and travel with the entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_zero <= 1'b0;
      r_h_neg  <= 1'b0;
      r_t_zero <= 1'b0;
      r_t_neg  <= 1'b0;
    end else begin
      if (w_ld_in) begin
        r_h_zero <= w_zero;
        r_h_neg  <= w_neg;
      end else if (w_shift) begin
        r_h_zero <= r_t_zero;
        r_h_neg  <= r_t_neg;
      end
      if (w_ld_tail) begin
        r_t_zero <= w_zero;
        r_t_neg  <= w_neg;
      end
    end
  end

  assign out_zero = out_valid && r_h_zero;
  assign out_neg  = out_valid && r_h_neg;
`else
  assign out_zero = 1'b0;
  assign out_neg  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed + random checks against a queue model.
// Flag expectations follow ALU_RESULT_FLAGS_EN as built.
module tb_alu_result_stage;

  localparam int BITS = 2;
  localparam int CNTB = 2;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic [1:0]      in_sel;
  logic [BITS-1:0] in_data;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] out_data;
  logic [1:0]      out_sel;
  logic            out_zero;
  logic            out_neg;
  logic [CNTB-1:0] acc_count;

  alu_result_stage #(.Bits(BITS), .CntBits(CNTB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .acc_count (acc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int acc   = 0;
  logic [BITS+1:0] q[$];

`ifdef ALU_RESULT_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [BITS-1:0] d;
    logic [1:0]      s;
    d = '0;
    s = '0;
    if (q.size() > 0) begin
      d = q[0][BITS-1:0];
      s = q[0][BITS+1:BITS];
    end
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() > 0));
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(q.size() < 2));
    chk({tag, ".out_data"}, 64'(out_data), 64'(d));
    chk({tag, ".out_sel"}, 64'(out_sel), 64'(s));
    chk({tag, ".out_zero"}, 64'(out_zero),
        64'(FLAGS && q.size() > 0 && d == 0));
    chk({tag, ".out_neg"}, 64'(out_neg),
        64'(FLAGS && q.size() > 0 && d[BITS-1]));
    chk({tag, ".acc_count"}, 64'(acc_count),
        64'(acc % (1 << CNTB)));
  endtask

  // One clock: predict transfers from the model, then compare after edge.
  task automatic cyc(input string tag);
    bit push;
    bit pop;
    pop  = out_ready && (q.size() > 0);
    push = in_valid && (q.size() - (pop ? 1 : 0) < 2) && (q.size() < 2);
    @(posedge clk);
    #1;
    if (pop)  void'(q.pop_front());
    if (push) begin
      q.push_back({in_sel, in_data});
      acc++;
    end
    check_all(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_data   = '0;
    out_ready = 1'b0;
    #2;
    check_all("reset");
    #10;
    rst_n = 1'b1;

    // Single transfer, accepted on the first edge after release.
    in_valid  = 1'b1;
    in_sel    = 2'd2;
    in_data   = 2'b10;
    out_ready = 1'b1;
    cyc("single");
    chk("single.data", 64'(out_data), 64'd2);
    chk("single.cnt", 64'(acc_count), 64'd1);
    in_valid = 1'b0;
    cyc("single.drain");

    // Back-pressure: third input held off while full.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = BITS'(i);
      in_sel  = 2'(i);
      cyc("bp.fill");
    end
    chk("bp.held", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    cyc("bp.pop1");
    cyc("bp.pop2");
    in_valid = 1'b0;
    cyc("bp.pop3");
    cyc("bp.empty");

    // Streaming in ONE: one result per cycle.
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = BITS'(i);
      in_sel  = 2'(i >> 2);
      cyc("stream");
    end
    in_valid = 1'b0;
    cyc("stream.end");

    // Reset asserted between edges while FULL.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 2'd3;
    in_sel    = 2'd1;
    cyc("mid.fill1");
    in_data = 2'd1;
    cyc("mid.fill2");
    #3;
    rst_n = 1'b0;
    #1;
    q.delete();
    acc = 0;
    check_all("mid.rst");
    #2;
    rst_n    = 1'b1;
    in_data  = 2'd0;
    in_sel   = 2'd3;
    in_valid = 1'b1;
    cyc("mid.post");
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc("mid.drain");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = BITS'($urandom);
      in_sel    = 2'($urandom);
      cyc("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 The block SHALL take parameter Bits, default 2, as the result data width (legal range 2..64).
REQ-002 The block SHALL take parameter CntBits, default 8, as the accepted-result counter width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream result-mux output holds a valid result.
REQ-006 in_sel  input  2  mux select that produced in_data; carried as an operation tag.
REQ-007 in_data  input  Bits  result-mux output.
REQ-008 in_ready  output  1  stage can accept a result this cycle.
REQ-009 out_valid  output  1  out_* holds the oldest buffered result.
REQ-010 out_ready  input  1  downstream consumes the head result this cycle.
REQ-011 out_data  output  Bits  head result data.
REQ-012 out_sel  output  2  head result tag.
REQ-013 out_zero  output  1  head result equals zero.
REQ-014 out_neg  output  1  head result MSB (in_data[Bits-1]).
REQ-015 acc_count  output  CntBits  number of results accepted since reset, modulo 2^CntBits.

Function
REQ-016 The stage SHALL be a 2-entry in-order buffer with states EMPTY, ONE, FULL.
REQ-017 An input transfer SHALL occur when in_valid && in_ready; an output transfer when out_valid && out_ready.
REQ-018 in_ready SHALL be 1 in EMPTY and ONE, and 0 in FULL; it SHALL be a registered or state-decoded signal with no combinational path from out_ready.
REQ-019 out_valid SHALL be 1 in ONE and FULL, and 0 in EMPTY.
REQ-020 Transitions: EMPTY->ONE on input only; ONE->FULL on input without output; ONE->EMPTY on output without input; ONE->ONE on simultaneous input and output; FULL->ONE on output; all other cases hold.
REQ-021 Latency SHALL be one cycle: a result accepted at edge N SHALL appear on out_* after edge N when the buffer was EMPTY.
REQ-022 Results SHALL leave in acceptance order, with no loss or duplication, under any pattern of in_valid and out_ready.
REQ-023 In FULL with in_valid=1 and out_ready=1, only the output transfer SHALL occur; the input is held off by in_ready=0 and accepted on a later cycle.
REQ-024 out_data, out_sel, out_zero and out_neg SHALL be stable while out_valid=1 and out_ready=0.
REQ-025 out_zero and out_neg SHALL be computed at acceptance and stored with the entry, not recomputed from out_data.
REQ-026 acc_count SHALL increment by 1 on each input transfer and SHALL wrap from 2^CntBits-1 to 0.
REQ-027 When out_valid=0, out_data, out_sel, out_zero and out_neg SHALL be 0.

Reset
REQ-028 On rst_n=0, the state SHALL go to EMPTY immediately, regardless of clk.
REQ-029 Reset values: in_ready=1, out_valid=0, out_data=0, out_sel=0, out_zero=0, out_neg=0, acc_count=0.
REQ-030 Buffered entries SHALL be discarded on reset, including reset asserted mid-transfer; no entry SHALL reappear after reset.
REQ-031 Reset release SHALL be recognised on the first clk edge after rst_n rises; inputs presented at that edge SHALL be accepted.

Configuration
REQ-032 Macro ALU_RESULT_FLAGS_EN SHALL control flag generation.
REQ-033 With ALU_RESULT_FLAGS_EN defined, out_zero and out_neg SHALL behave per REQ-013, REQ-014 and REQ-025.
REQ-034 Without ALU_RESULT_FLAGS_EN, out_zero and out_neg SHALL be tied to 0, no flag storage SHALL be built, and all other behaviour SHALL be unchanged.

Verification
REQ-035 Single transfer: Bits=2, reset, then in_valid=1, in_sel=2, in_data=2'b10 for one cycle with out_ready=1 -> next cycle out_valid=1, out_data=2, out_sel=2, out_neg=1, out_zero=0, acc_count=1.
REQ-036 Back-pressure: out_ready=0, three consecutive inputs 1, 2, 3 -> in_ready=0 after two acceptances; then out_ready=1 -> outputs 1, 2, 3 in order, acc_count=3.
REQ-037 Simultaneous in/out in ONE: streaming inputs 0..15 with out_ready=1 throughout -> one result per cycle, state stays ONE, first result out_zero=1.
REQ-038 Counter wrap: CntBits=2, five acceptances -> acc_count sequence 1, 2, 3, 0, 1.
REQ-039 Reset mid-operation: FULL state, assert rst_n=0 between edges -> out_valid=0 and in_ready=1 immediately; after release no stale data is output.
REQ-040 Macro off: rebuild without ALU_RESULT_FLAGS_EN and rerun REQ-035 -> out_neg=0 and out_zero=0, data identical.
